if_ex_tracker: RTL and testbench
================================

IF_EX_TRACKER -- requirements
Module: if_ex_tracker

Interface
REQ-001 The parameters SHALL be: INSTR_DATA_WIDTH, default 32, fetched instruction width; DATA_ADDR_WIDTH, default 32, data address width; TRACE_BUFFER_SIZE, default 64, fetch FIFO depth (power of two, at least 2).
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-high.
REQ-004 jump_done  input  1  the processor resolved a jump this cycle.
REQ-005 instr_rvalid  input  1  the instruction-memory read data is valid.
REQ-006 instr_rdata  input  INSTR_DATA_WIDTH  the fetched instruction.
REQ-007 data_mem_req, data_mem_grant, data_mem_rvalid  input  1 each  data-memory request, grant and response-valid.
REQ-008 data_mem_addr  input  DATA_ADDR_WIDTH  the data request address.
REQ-009 trace_valid  output  1  a one-cycle pulse marking a completed trace record.
REQ-010 trace_instr  output  INSTR_DATA_WIDTH  the traced instruction.
REQ-011 trace_if_time, trace_ex_start, trace_ex_end  output  32 each  cycle timestamps.
REQ-012 trace_mem_addr  output  DATA_ADDR_WIDTH  the data address, or 0 for a non-memory instruction.
REQ-013 trace_is_mem  output  1  the record is a load or store.
REQ-014 overflow  output  1  sticky flag: a fetch was dropped because the FIFO was full.

Function
REQ-015 A 32-bit counter SHALL increment by 1 every clock, wrapping from 0xFFFFFFFF to 0, so the first post-reset edge reads 0.
REQ-016 When instr_rvalid=1 and jump_done=0, the block SHALL push {instr_rdata, counter} into the FIFO.
REQ-017 When instr_rvalid=1 and jump_done=1 in the same cycle, the fetch SHALL be discarded as wrong-path.
REQ-018 A memory instruction SHALL be one with instr[6:0]=7'b0000011 (load) or 7'b0100011 (store); every other opcode is a non-memory instruction.
REQ-019 The EX engine SHALL have four states: IDLE, WAIT_GNT, WAIT_RVALID and EMIT.
REQ-020 In IDLE with the FIFO non-empty, the engine SHALL pop the head entry.
REQ-021 A popped non-memory instruction SHALL set ex_start = ex_end = the counter at the pop and go to EMIT.
REQ-022 A popped memory instruction SHALL go to WAIT_GNT.
REQ-023 In WAIT_GNT, on the first cycle with data_mem_req=1 and data_mem_grant=1, the engine SHALL latch data_mem_addr and ex_start = counter, then go to WAIT_RVALID.
REQ-024 In WAIT_RVALID, on data_mem_rvalid=1, the engine SHALL latch ex_end = counter and go to EMIT.
REQ-025 A data_mem_rvalid seen in WAIT_GNT SHALL be ignored.
REQ-026 EMIT SHALL drive trace_valid=1 for exactly one cycle with the registered fields, then return to IDLE.
REQ-027 The EX engine SHALL emit at most one record every 2 cycles, and records SHALL appear in fetch order.
REQ-028 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-029 A push while the FIFO is full with no pop that cycle SHALL be dropped.
REQ-030 When trace_valid=0, all trace_* outputs SHALL hold their last values.

Reset
REQ-031 While rst_n=1, the following SHALL apply: counter = 0xFFFFFFFF; FIFO empty; engine in IDLE; trace_valid=0; all trace_* fields 0; overflow=0.
REQ-032 Reset asserted mid-transaction SHALL abandon the in-flight record, and that record SHALL never be emitted.

Configuration
REQ-033 With IF_EX_TRACKER_OVERFLOW_EN defined, overflow SHALL set on any dropped push and clear only on reset.
REQ-034 Without IF_EX_TRACKER_OVERFLOW_EN, overflow SHALL be tied to 0 and no sticky register is instantiated.
REQ-035 All other behaviour SHALL be identical with and without IF_EX_TRACKER_OVERFLOW_EN.

Verification
REQ-036 Scenario, non-memory record: release reset, then at counter=5 fetch instr 0x00500093 (addi) -> trace_valid, trace_instr=0x00500093, trace_if_time=5, trace_is_mem=0, trace_mem_addr=0, ex_start=ex_end.
REQ-037 Scenario, load record: fetch 0x0000A103 (lw) at counter=10; req+grant with addr 0x1000 at counter=14; rvalid at counter=17 -> trace_is_mem=1, trace_mem_addr=0x1000, ex_start=14, ex_end=17.
REQ-038 Scenario, wrong-path fetch: instr_rvalid and jump_done both high for instr 0x00000013 -> no record for it; the following fetch traces normally.
REQ-039 Scenario, full FIFO: with data_mem_grant held 0 behind a store, push 66 fetches -> exactly 64 buffered (63 after one pop), the excess dropped, overflow=1 with the macro and 0 without.
REQ-040 Scenario, reset mid-transaction: assert rst_n while in WAIT_RVALID -> trace_valid stays 0, FIFO empty, counter reads 0 on the first edge after release.

Source files
------------

// File: rtl/if_ex_tracker_if.sv
// Bundle of fetch-side, data-memory-side and trace-record signals for if_ex_tracker.
// master drives the processor observations; slave is the tracker producing trace records.
interface if_ex_tracker_if #(
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int DATA_ADDR_WIDTH  = 32
);
    logic                        jump_done;
    logic                        instr_rvalid;
    logic [INSTR_DATA_WIDTH-1:0] instr_rdata;
    logic                        data_mem_req;
    logic                        data_mem_grant;
    logic                        data_mem_rvalid;
    logic [DATA_ADDR_WIDTH-1:0]  data_mem_addr;

    logic                        trace_valid;
    logic [INSTR_DATA_WIDTH-1:0] trace_instr;
    logic [31:0]                 trace_if_time;
    logic [31:0]                 trace_ex_start;
    logic [31:0]                 trace_ex_end;
    logic [DATA_ADDR_WIDTH-1:0]  trace_mem_addr;
    logic                        trace_is_mem;
    logic                        overflow;

    modport master (
        output jump_done, instr_rvalid, instr_rdata,
               data_mem_req, data_mem_grant, data_mem_rvalid, data_mem_addr,
        input  trace_valid, trace_instr, trace_if_time, trace_ex_start,
               trace_ex_end, trace_mem_addr, trace_is_mem, overflow
    );

    modport slave (
        input  jump_done, instr_rvalid, instr_rdata,
               data_mem_req, data_mem_grant, data_mem_rvalid, data_mem_addr,
        output trace_valid, trace_instr, trace_if_time, trace_ex_start,
               trace_ex_end, trace_mem_addr, trace_is_mem, overflow
    );
endinterface

// File: rtl/if_ex_tracker.sv
// Fetch-to-execute tracker: buffers fetched instructions with timestamps and emits one trace
// record per instruction. Define IF_EX_TRACKER_OVERFLOW_EN for a sticky dropped-fetch flag.
module if_ex_tracker #(
    parameter int INSTR_DATA_WIDTH  = 32,
    parameter int DATA_ADDR_WIDTH   = 32,
    parameter int TRACE_BUFFER_SIZE = 64
) (
    input  logic clk,
    input  logic rst_n,
    if_ex_tracker_if.slave bus
);
    localparam int              PTR_W    = $clog2(TRACE_BUFFER_SIZE);
    localparam logic [PTR_W:0]  PTR_ONE  = 1;
    localparam logic [6:0]      OP_LOAD  = 7'b0000011;
    localparam logic [6:0]      OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, EMIT} state_t;

    typedef struct packed {
        logic [INSTR_DATA_WIDTH-1:0] instr;
        logic [31:0]                 if_time;
    } entry_t;

    logic [31:0]                 counter;
    entry_t                      fifo_mem [TRACE_BUFFER_SIZE];
    logic [PTR_W:0]              wr_ptr, rd_ptr;
    state_t                      state;
    logic [INSTR_DATA_WIDTH-1:0] cur_instr;
    logic [31:0]                 cur_if_time, cur_ex_start;
    logic [DATA_ADDR_WIDTH-1:0]  cur_addr;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic   fifo_empty, fifo_full, fetch_ok, push, pop, head_is_mem;
    entry_t head;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fetch_ok    = bus.instr_rvalid && !bus.jump_done;
    assign pop         = (state == IDLE) && !fifo_empty;
    assign push        = fetch_ok && (!fifo_full || pop);
    assign head        = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign head_is_mem = (head.instr[6:0] == OP_LOAD) || (head.instr[6:0] == OP_STORE);

    // NOTE: reset here is active-high and asynchronous, hence posedge rst_n in the sensitivity list.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            counter <= 32'hFFFF_FFFF;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            counter <= counter + 32'd1;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= {bus.instr_rdata, counter};
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state              <= IDLE;
            cur_instr          <= '0;
            cur_if_time        <= '0;
            cur_ex_start       <= '0;
            cur_addr           <= '0;
            bus.trace_valid    <= 1'b0;
            bus.trace_instr    <= '0;
            bus.trace_if_time  <= '0;
            bus.trace_ex_start <= '0;
            bus.trace_ex_end   <= '0;
            bus.trace_mem_addr <= '0;
            bus.trace_is_mem   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_is_mem) begin
                            cur_instr   <= head.instr;
                            cur_if_time <= head.if_time;
                            state       <= WAIT_GNT;
                        end else begin
                            bus.trace_instr    <= head.instr;
                            bus.trace_if_time  <= head.if_time;
                            bus.trace_ex_start <= counter;
                            bus.trace_ex_end   <= counter;
                            bus.trace_mem_addr <= '0;
                            bus.trace_is_mem   <= 1'b0;
                            bus.trace_valid    <= 1'b1;
                            state              <= EMIT;
                        end
                    end
                end
                WAIT_GNT: begin
                    if (bus.data_mem_req && bus.data_mem_grant) begin
                        cur_addr     <= bus.data_mem_addr;
                        cur_ex_start <= counter;
                        state        <= WAIT_RVALID;
                    end
                end
                WAIT_RVALID: begin
                    // Output fields change only when a record is published, so they hold otherwise.
                    if (bus.data_mem_rvalid) begin
                        bus.trace_instr    <= cur_instr;
                        bus.trace_if_time  <= cur_if_time;
                        bus.trace_ex_start <= cur_ex_start;
                        bus.trace_ex_end   <= counter;
                        bus.trace_mem_addr <= cur_addr;
                        bus.trace_is_mem   <= 1'b1;
                        bus.trace_valid    <= 1'b1;
                        state              <= EMIT;
                    end
                end
                EMIT: begin
                    bus.trace_valid <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IF_EX_TRACKER_OVERFLOW_EN
    logic drop, overflow_q;
    assign drop = fetch_ok && fifo_full && !pop;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)     overflow_q <= 1'b0;
        else if (drop) overflow_q <= 1'b1;
    end

    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_if_ex_tracker.sv
// Self-checking bench for if_ex_tracker: directed scenarios plus randomized traffic checked
// against a transaction-level model computed from the logged input history.
module tb_if_ex_tracker;
    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int MAXC  = 8192;
    localparam int INF   = 1 << 30;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_ex_tracker_if #(.INSTR_DATA_WIDTH(IW), .DATA_ADDR_WIDTH(AW)) bus ();

    if_ex_tracker #(
        .INSTR_DATA_WIDTH (IW),
        .DATA_ADDR_WIDTH  (AW),
        .TRACE_BUFFER_SIZE(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] ift;
        logic [31:0] xs;
        logic [31:0] xe;
        logic [31:0] addr;
        logic        mem;
    } rec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    rec_t obs[$];
    rec_t exp_q[$];

    bit          lg_fetch [MAXC];
    bit          lg_jump  [MAXC];
    bit          lg_rg    [MAXC];
    bit          lg_rv    [MAXC];
    logic [31:0] lg_instr [MAXC];
    logic [31:0] lg_addr  [MAXC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=0x%08h want=0x%08h", tag, got, want);
        end
    endtask

    // Record collector and hold check: between records every trace field must stay put.
    rec_t mon_last;
    bit   mon_prev_ok = 1'b0;
    always @(negedge clk) begin
        rec_t cur;
        cur.instr = bus.trace_instr;
        cur.ift   = bus.trace_if_time;
        cur.xs    = bus.trace_ex_start;
        cur.xe    = bus.trace_ex_end;
        cur.addr  = bus.trace_mem_addr;
        cur.mem   = bus.trace_is_mem;
        if (rst_n !== 1'b0) begin
            mon_prev_ok = 1'b0;
        end else begin
            if (bus.trace_valid === 1'b1) begin
                obs.push_back(cur);
            end else if (mon_prev_ok) begin
                checks++;
                assert (cur === mon_last) else begin
                    errors++;
                    $error("FAIL hold got=%h want=%h", cur, mon_last);
                end
            end
            mon_last    = cur;
            mon_prev_ok = 1'b1;
        end
    end

    task automatic step(input bit f, input bit j, input logic [31:0] ins,
                        input bit rq, input bit gn, input bit rv, input logic [31:0] ad);
        bus.instr_rvalid    = f;
        bus.jump_done       = j;
        bus.instr_rdata     = ins;
        bus.data_mem_req    = rq;
        bus.data_mem_grant  = gn;
        bus.data_mem_rvalid = rv;
        bus.data_mem_addr   = ad;
        if (cyc < MAXC) begin
            lg_fetch[cyc] = f;
            lg_jump[cyc]  = j;
            lg_instr[cyc] = ins;
            lg_rg[cyc]    = rq && gn;
            lg_rv[cyc]    = rv;
            lg_addr[cyc]  = ad;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    task automatic do_reset();
        rst_n               = 1'b1;
        bus.instr_rvalid    = 1'b0;
        bus.jump_done       = 1'b0;
        bus.instr_rdata     = '0;
        bus.data_mem_req    = 1'b0;
        bus.data_mem_grant  = 1'b0;
        bus.data_mem_rvalid = 1'b0;
        bus.data_mem_addr   = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset trace_valid", {31'd0, bus.trace_valid}, 32'd0);
        chk("reset trace_instr", bus.trace_instr, 32'd0);
        chk("reset trace_if_time", bus.trace_if_time, 32'd0);
        chk("reset trace_ex_end", bus.trace_ex_end, 32'd0);
        chk("reset trace_mem_addr", bus.trace_mem_addr, 32'd0);
        chk("reset overflow", {31'd0, bus.overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        obs.delete();
        for (int i = 0; i < MAXC; i++) begin
            lg_fetch[i] = 0; lg_jump[i] = 0; lg_rg[i] = 0; lg_rv[i] = 0;
            lg_instr[i] = '0; lg_addr[i] = '0;
        end
    endtask

    // Model: cycle number == counter value. Each accepted fetch is popped as soon as the
    // engine is free and the entry is visible; its record timing follows from the logged
    // grant/rvalid history. Drops happen when 64 entries are resident and nothing leaves.
    task automatic build_expect(input int ncyc, output bit dropped);
        int   pops[$];
        int   free_t, occ, p, s, e;
        bit   pop_now, is_mem;
        rec_t r;
        exp_q.delete();
        dropped = 1'b0;
        free_t  = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (!lg_fetch[c] || lg_jump[c]) continue;
            occ     = 0;
            pop_now = 1'b0;
            foreach (pops[k]) begin
                if (pops[k] >= c) occ++;
                if (pops[k] == c) pop_now = 1'b1;
            end
            if (occ >= DEPTH && !pop_now) begin
                dropped = 1'b1;
                continue;
            end
            p = (free_t > c + 1) ? free_t : c + 1;
            pops.push_back(p);
            if (p >= INF) continue;
            is_mem  = (lg_instr[c][6:0] == 7'b0000011) || (lg_instr[c][6:0] == 7'b0100011);
            r.instr = lg_instr[c];
            r.ift   = c;
            r.mem   = is_mem;
            if (!is_mem) begin
                r.xs   = p;
                r.xe   = p;
                r.addr = 0;
                free_t = p + 2;
            end else begin
                s = -1;
                e = -1;
                for (int t = p + 1; t < ncyc; t++) if (lg_rg[t]) begin s = t; break; end
                if (s >= 0) for (int t = s + 1; t < ncyc; t++) if (lg_rv[t]) begin e = t; break; end
                if (e < 0) begin
                    free_t = INF;
                    continue;
                end
                r.xs   = s;
                r.xe   = e;
                r.addr = lg_addr[s];
                free_t = e + 2;
            end
            if (free_t - 1 < ncyc) exp_q.push_back(r);
        end
    endtask

    task automatic end_epoch(input string tag);
        bit dr;
        bit want_ovf;
        build_expect(cyc, dr);
`ifdef IF_EX_TRACKER_OVERFLOW_EN
        want_ovf = dr;
`else
        want_ovf = 1'b0;
`endif
        chk({tag, " record count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk($sformatf("%s rec%0d instr", tag, i), obs[i].instr, exp_q[i].instr);
            chk($sformatf("%s rec%0d if_time", tag, i), obs[i].ift, exp_q[i].ift);
            chk($sformatf("%s rec%0d ex_start", tag, i), obs[i].xs, exp_q[i].xs);
            chk($sformatf("%s rec%0d ex_end", tag, i), obs[i].xe, exp_q[i].xe);
            chk($sformatf("%s rec%0d mem_addr", tag, i), obs[i].addr, exp_q[i].addr);
            chk($sformatf("%s rec%0d is_mem", tag, i), {31'd0, obs[i].mem}, {31'd0, exp_q[i].mem});
        end
        chk({tag, " overflow"}, {31'd0, bus.overflow}, {31'd0, want_ovf});
    endtask

    initial begin
        bit          f, j, rq, gn, rv;
        int          k;
        logic [31:0] ins;
        logic [31:0] want_ovf;

        // Epoch 1: non-memory record, load record, wrong-path fetch.
        do_reset();
        idle(5);
        step(1, 0, 32'h0050_0093, 0, 0, 0, 32'h0);       // cycle 5
        idle(4);
        step(1, 0, 32'h0000_A103, 0, 0, 0, 32'h0);       // cycle 10
        idle(2);
        step(0, 0, 32'h0, 1, 0, 1, 32'hDEAD_0000);        // cycle 13: rvalid in WAIT_GNT ignored
        step(0, 0, 32'h0, 1, 1, 0, 32'h0000_1000);        // cycle 14: req+grant
        idle(2);
        step(0, 0, 32'h0, 0, 0, 1, 32'h0);                // cycle 17: rvalid
        idle(2);
        step(1, 1, 32'h0000_0013, 0, 0, 0, 32'h0);        // cycle 20: wrong path
        idle(1);
        step(1, 0, 32'h0010_0113, 0, 0, 0, 32'h0);        // cycle 22
        idle(8);
        chk("dir record count", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("addi instr", obs[0].instr, 32'h0050_0093);
            chk("addi if_time", obs[0].ift, 32'd5);
            chk("addi is_mem", {31'd0, obs[0].mem}, 32'd0);
            chk("addi mem_addr", obs[0].addr, 32'd0);
            chk("addi ex_start", obs[0].xs, 32'd6);
            chk("addi ex_end", obs[0].xe, 32'd6);
            chk("lw if_time", obs[1].ift, 32'd10);
            chk("lw is_mem", {31'd0, obs[1].mem}, 32'd1);
            chk("lw mem_addr", obs[1].addr, 32'h0000_1000);
            chk("lw ex_start", obs[1].xs, 32'd14);
            chk("lw ex_end", obs[1].xe, 32'd17);
            chk("after wrong path instr", obs[2].instr, 32'h0010_0113);
            chk("after wrong path if_time", obs[2].ift, 32'd22);
        end
        end_epoch("dir");

        // Epoch 2: FIFO fills behind a stalled store; then a push coinciding with a pop at full.
        do_reset();
        step(1, 0, 32'h0020_A023, 0, 0, 0, 32'h0);       // cycle 0: store, popped at cycle 1
        idle(1);
        for (int i = 0; i < 66; i++) begin                // cycles 2..67
            ins = 32'h0000_0093 | (i << 20);
            step(1, 0, ins, 0, 0, 0, 32'h0);
        end
`ifdef IF_EX_TRACKER_OVERFLOW_EN
        want_ovf = 32'd1;
`else
        want_ovf = 32'd0;
`endif
        chk("full overflow", {31'd0, bus.overflow}, want_ovf);
        step(0, 0, 32'h0, 1, 1, 0, 32'h0000_2000);        // cycle 68: grant
        step(0, 0, 32'h0, 0, 0, 1, 32'h0);                // cycle 69: rvalid
        idle(1);                                          // cycle 70: EMIT
        step(1, 0, 32'h7FF0_0093, 0, 0, 0, 32'h0);        // cycle 71: push with pop at full
        idle(200);
        chk("full record count", obs.size(), 66);
        if (obs.size() == 66) begin
            chk("full store addr", obs[0].addr, 32'h0000_2000);
            chk("full last buffered", obs[64].instr, 32'h03F0_0093);
            chk("full push at pop", obs[65].instr, 32'h7FF0_0093);
        end
        end_epoch("full");

        // Epoch 3: reset while waiting for rvalid.
        do_reset();
        step(1, 0, 32'h0000_A103, 0, 0, 0, 32'h0);       // cycle 0: lw
        step(1, 0, 32'h0030_0093, 0, 0, 0, 32'h0);       // cycle 1: queued behind lw
        idle(1);
        step(0, 0, 32'h0, 1, 1, 0, 32'h0000_3000);        // cycle 3: grant
        idle(1);                                          // now in WAIT_RVALID
        rst_n = 1'b1;
        bus.data_mem_rvalid = 1'b1;
        #1;
        chk("midrst trace_valid", {31'd0, bus.trace_valid}, 32'd0);
        chk("midrst records before reset", obs.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst trace_valid held", {31'd0, bus.trace_valid}, 32'd0);
        do_reset();
        step(1, 0, 32'h00A0_0093, 0, 0, 0, 32'h0);       // cycle 0 after release
        step(0, 0, 32'h0, 0, 0, 1, 32'h0);
        idle(10);
        chk("midrst record count", obs.size(), 1);
        if (obs.size() == 1) chk("midrst if_time", obs[0].ift, 32'd0);
        end_epoch("midrst");

        // Epoch 4: random traffic with a responsive memory.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            f   = ($urandom % 10) < 6;
            j   = ($urandom % 10) == 0;
            k   = $urandom % 4;
            ins = $urandom;
            if (k == 0)      ins[6:0] = 7'b0000011;
            else if (k == 1) ins[6:0] = 7'b0100011;
            rq = $urandom % 2;
            gn = $urandom % 2;
            rv = ($urandom % 10) < 3;
            step(f, j, ins, rq, gn, rv, $urandom);
        end
        for (int i = 0; i < 400; i++) step(0, 0, 32'h0, 1, 1, 1, $urandom);
        end_epoch("rand_fast");

        // Epoch 5: random traffic with a slow memory so the FIFO saturates.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            f   = ($urandom % 10) < 9;
            j   = ($urandom % 16) == 0;
            k   = $urandom % 3;
            ins = $urandom;
            if (k == 0)      ins[6:0] = 7'b0000011;
            else if (k == 1) ins[6:0] = 7'b0100011;
            rq = ($urandom % 5) == 0;
            gn = ($urandom % 4) == 0;
            rv = ($urandom % 8) == 0;
            step(f, j, ins, rq, gn, rv, $urandom);
        end
        for (int i = 0; i < 500; i++) step(0, 0, 32'h0, 1, 1, 1, $urandom);
        end_epoch("rand_slow");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
